// File: rtl/ddr_rx_aligner_pkg.sv
// Shared types and constants for the DDR receive word aligner.
// It holds the FSM state encoding, the default training word and a saturating counter helper.
package ddr_rx_aligner_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hBC;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ddr_rx_aligner_window.sv
// History window for the IDDR bit pair stream, plus both candidate word compares.
// Two candidates at adjacent bit offsets cover every alignment because the window advances two bits per clock.
module ddr_rx_window
  import ddr_rx_aligner_pkg::*;
#(
  parameter int                    WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD  = WORD_WIDTH'(DEFAULT_SYNC_WORD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  q1,
  input  logic                  q2,
  output logic [WORD_WIDTH-1:0] c0,
  output logic [WORD_WIDTH-1:0] c1,
  output logic                  match0,
  output logic                  match1
);

  logic [WORD_WIDTH:0] hist_q;
  logic [WORD_WIDTH:0] hist_d;

  // Q1 is the earlier bit, so it lands one place above Q2.
  always_comb begin
    hist_d = {hist_q[WORD_WIDTH-2:0], q1, q2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign c0     = hist_q[WORD_WIDTH-1:0];
  assign c1     = hist_q[WORD_WIDTH:1];
  assign match0 = (c0 == SYNC_WORD);
  assign match1 = (c1 == SYNC_WORD);

endmodule

// File: rtl/ddr_rx_aligner.sv
// Word aligner and lock controller for the IDDR two-bit-per-clock stream.
// It searches for a sync word, verifies a run of them, then emits aligned words with a valid strobe.
module ddr_rx_aligner
  import ddr_rx_aligner_pkg::*;
#(
  parameter int                    WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD  = WORD_WIDTH'(DEFAULT_SYNC_WORD),
  parameter int                    LOCK_COUNT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic                  RESYNC,
  input  logic                  Q1,
  input  logic                  Q2,
  output logic [WORD_WIDTH-1:0] DATA,
  output logic                  DATA_VALID,
  output logic                  LOCKED,
  output logic                  BIT_OFFSET,
  output logic [7:0]            SYNC_ERR_CNT
);

  localparam int              HALF      = WORD_WIDTH / 2;
  localparam int              PH_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(HALF - 1);
  localparam logic [7:0]      LOCK_CNT8 = 8'(LOCK_COUNT);

  logic [WORD_WIDTH-1:0] c0;
  logic [WORD_WIDTH-1:0] c1;
  logic                  match0;
  logic                  match1;

  ddr_rx_window #(
    .WORD_WIDTH (WORD_WIDTH),
    .SYNC_WORD  (SYNC_WORD)
  ) u_window (
    .clk    (CLK),
    .rst_n  (RST_N),
    .q1     (Q1),
    .q2     (Q2),
    .c0     (c0),
    .c1     (c1),
    .match0 (match0),
    .match1 (match1)
  );

  state_e                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            err_q, err_d;
  logic                  off_q, off_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  locked_q, locked_d;

  logic                  boundary;
  logic                  sel_match;
  logic [WORD_WIDTH-1:0] sel_word;

  assign boundary  = (phase_q == PH_LAST);
  assign sel_match = off_q ? match1 : match0;
  assign sel_word  = off_q ? c1 : c0;

  always_comb begin
    state_d = state_q;
    phase_d = boundary ? '0 : phase_q + PH_W'(1);
    cnt_d   = cnt_q;
    err_d   = err_q;
    off_d   = off_q;
    data_d  = data_q;
    valid_d = 1'b0;

    if (!ENABLE || RESYNC) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          // The detection clock is itself a word boundary, so phase restarts here.
          if (match0 || match1) begin
            off_d   = ~match0;
            phase_d = '0;
            cnt_d   = 8'd1;
            state_d = (LOCK_CNT8 == 8'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (sel_match) begin
              cnt_d = cnt_q + 8'd1;
              if (cnt_q + 8'd1 == LOCK_CNT8) begin
                state_d = ST_LOCKED;
              end
            end else begin
              state_d = ST_SEARCH;
              cnt_d   = '0;
              err_d   = sat_inc8(err_q);
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            data_d  = sel_word;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_SEARCH;
      phase_q  <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      off_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      off_q    <= off_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign DATA         = data_q;
  assign DATA_VALID   = valid_q;
  assign LOCKED       = locked_q;
  assign BIT_OFFSET   = off_q;
  assign SYNC_ERR_CNT = err_q;

endmodule

// File: tb/tb_ddr_rx_aligner.sv
// Scoreboard bench for ddr_rx_aligner: an 8-bit instance for training, errors, resync and reset,
// and a 2-bit instance with single-word lock.
module tb_ddr_rx_aligner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, resync, q1, q2;
  logic [7:0] data;
  logic       data_valid, locked, bit_offset;
  logic [7:0] err_cnt;

  logic       en2, rs2, q1b, q2b;
  logic [1:0] data2;
  logic       vld2, lock2, off2;
  logic [7:0] err2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_vld = -1;
  int last_vld2 = -1;
  logic       lock_prev;
  logic [7:0] exp_q[$];
  logic [1:0] exp2_q[$];
  logic       bits[$];
  int         rise_q[$];
  int         fall_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_rx_aligner #(
    .WORD_WIDTH (8),
    .SYNC_WORD  (8'hBC),
    .LOCK_COUNT (4)
  ) u_dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .ENABLE       (enable),
    .RESYNC       (resync),
    .Q1           (q1),
    .Q2           (q2),
    .DATA         (data),
    .DATA_VALID   (data_valid),
    .LOCKED       (locked),
    .BIT_OFFSET   (bit_offset),
    .SYNC_ERR_CNT (err_cnt)
  );

  ddr_rx_aligner #(
    .WORD_WIDTH (2),
    .SYNC_WORD  (2'b10),
    .LOCK_COUNT (1)
  ) u_dut2 (
    .CLK          (clk),
    .RST_N        (rst_n),
    .ENABLE       (en2),
    .RESYNC       (rs2),
    .Q1           (q1b),
    .Q2           (q2b),
    .DATA         (data2),
    .DATA_VALID   (vld2),
    .LOCKED       (lock2),
    .BIT_OFFSET   (off2),
    .SYNC_ERR_CNT (err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_word(input logic [7:0] w, input bit out);
    for (int i = 7; i >= 0; i--) bits.push_back(w[i]);
    if (out) exp_q.push_back(w);
  endtask

  task automatic observe(input int k);
    if (locked !== lock_prev) begin
      if (locked === 1'b1) rise_q.push_back(k - 1);
      else fall_q.push_back(k - 1);
      lock_prev = locked;
    end
  endtask

  // Plays the queued bit stream one pair per clock; pair k is captured at relative edge k.
  task automatic play(input int dis_lo, input int dis_hi, input int rs_at);
    int k;
    while (bits.size() % 2 != 0) bits.push_back(1'b0);
    bits.push_back(1'b0);
    bits.push_back(1'b0);
    rise_q.delete();
    fall_q.delete();
    lock_prev = locked;
    k = 0;
    while (bits.size() > 0) begin
      @(negedge clk);
      observe(k);
      q1     = bits.pop_front();
      q2     = bits.pop_front();
      enable = !(k >= dis_lo && k <= dis_hi);
      resync = (k == rs_at);
      k++;
    end
    @(negedge clk);
    observe(k);
    resync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable = 1'b0;
      resync = 1'b0;
      q1     = 1'b0;
      q2     = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) check("w8_spurious_vld", 1, 0);
      else check("w8_data", data, exp_q.pop_front());
      if (last_vld >= 0 && cyc - last_vld < 16) check("w8_vld_gap", cyc - last_vld, 4);
      last_vld = cyc;
    end
    if (vld2 === 1'b1) begin
      if (exp2_q.size() == 0) check("w2_spurious_vld", 1, 0);
      else check("w2_data", data2, exp2_q.pop_front());
      if (last_vld2 >= 0 && cyc - last_vld2 < 4) check("w2_vld_gap", cyc - last_vld2, 1);
      last_vld2 = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] p;
    rst_n = 1'b0; enable = 1'b0; resync = 1'b0; q1 = 1'b0; q2 = 1'b0;
    en2 = 1'b0; rs2 = 1'b0; q1b = 1'b0; q2b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_offset", bit_offset, 0);
    check("rst_err", err_cnt, 0);
    check("rst_lock2", lock2, 0);
    rst_n = 1'b1;
    idle(3);

    // Aligned training, then two payload words
    repeat (4) add_word(8'hBC, 0);
    add_word(8'h12, 1);
    add_word(8'h34, 1);
    play(-1, -1, -1);
    check("t1_rises", rise_q.size(), 1);
    check("t1_lock_edge", (rise_q.size() > 0) ? rise_q[0] : -1, 16);
    check("t1_offset", bit_offset, 0);
    check("t1_err", err_cnt, 0);
    idle(6);

    // Odd alignment: one leading zero bit
    bits.push_back(1'b0);
    repeat (4) add_word(8'hBC, 0);
    add_word(8'h12, 1);
    add_word(8'h34, 1);
    play(-1, -1, -1);
    check("t2_lock_edge", (rise_q.size() > 0) ? rise_q[0] : -1, 17);
    check("t2_offset", bit_offset, 1);
    idle(6);

    // Verify failure on the third word, then a clean lock
    add_word(8'hBC, 0);
    add_word(8'hBC, 0);
    add_word(8'h00, 0);
    repeat (4) add_word(8'hBC, 0);
    add_word(8'h12, 1);
    add_word(8'h34, 1);
    play(-1, -1, -1);
    check("t3_err", err_cnt, 1);
    check("t3_lock_edge", (rise_q.size() > 0) ? rise_q[0] : -1, 28);
    check("t3_offset", bit_offset, 0);
    idle(6);

    // ENABLE low for three clocks mid-training, lock, then RESYNC and relock
    repeat (6) add_word(8'hBC, 0);
    add_word(8'h12, 1);
    add_word(8'h34, 1);
    add_word(8'h56, 0);
    repeat (4) add_word(8'hBC, 0);
    add_word(8'h9A, 1);
    play(9, 11, 33);
    check("t4_rises", rise_q.size(), 2);
    check("t4_lock_edge", (rise_q.size() > 0) ? rise_q[0] : -1, 24);
    check("t4_unlock_edge", (fall_q.size() > 0) ? fall_q[0] : -1, 33);
    check("t4_relock_edge", (rise_q.size() > 1) ? rise_q[1] : -1, 52);
    check("t4_err", err_cnt, 1);
    idle(6);

    // Reset mid-VERIFY at odd offset
    bits.push_back(1'b0);
    add_word(8'hBC, 0);
    add_word(8'hBC, 0);
    play(-1, -1, -1);
    check("t5a_pre_offset", bit_offset, 1);
    check("t5a_pre_locked", locked, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5a_offset", bit_offset, 0);
    check("t5a_err", err_cnt, 0);
    check("t5a_locked", locked, 0);
    check("t5a_data", data, 0);
    @(negedge clk) rst_n = 1'b1;

    // Relock after release, then reset mid-LOCKED
    repeat (4) add_word(8'hBC, 0);
    add_word(8'h77, 1);
    play(-1, -1, -1);
    check("t5b_lock_edge", (rise_q.size() > 0) ? rise_q[0] : -1, 16);
    check("t5b_pre_data", data, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    check("t5b_data", data, 0);
    check("t5b_locked", locked, 0);
    check("t5b_valid", data_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);

    // Saturation of the sync error counter
    for (int i = 0; i < 254; i++) begin
      add_word(8'hBC, 0);
      add_word(8'h00, 0);
    end
    play(-1, -1, -1);
    check("t6_err_254", err_cnt, 254);
    for (int i = 0; i < 46; i++) begin
      add_word(8'hBC, 0);
      add_word(8'h00, 0);
    end
    play(-1, -1, -1);
    check("t6_err_sat", err_cnt, 255);
    check("t6_locked", locked, 0);
    idle(3);

    // Two-bit words, single-word lock: one strobe per clock
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) check("w2_lock_pre", lock2, 0);
      if (k == 4) check("w2_lock_rise", lock2, 1);
      if (k < 2) p = 2'b00;
      else if (k == 2) p = 2'b10;
      else p = 2'($urandom_range(0, 3));
      q1b = p[1];
      q2b = p[0];
      en2 = (k < 11);
      if (k >= 3 && k <= 9) exp2_q.push_back(p);
    end
    repeat (3) @(negedge clk);
    check("w2_offset", off2, 0);
    check("w2_err", err2, 0);
    check("w2_unlocked", lock2, 0);

    check("w8_leftover", exp_q.size(), 0);
    check("w2_leftover", exp2_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
